// File: rtl/butterfly_array.sv
// Multi-lane modular butterfly (NTT / INTT / pointwise) for Kyber-style datapaths.
// Fixed-latency pipeline; the whole pipe freezes while the output beat is held.
module butterfly_array #(
  parameter int LANES = 2,
  parameter int W     = 12,
  parameter int Q     = 3329,
  parameter int LAT   = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*W-1:0]        a_in,
  input  logic [LANES*W-1:0]        b_in,
  input  logic [LANES*W-1:0]        omega_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*W-1:0]        a_out,
  output logic [LANES*W-1:0]        b_out,
  output logic [$clog2(LAT+1):0]    inflight,
  output logic                      mode_err
);

  typedef enum logic [1:0] {M_NTT = 2'b00, M_INTT = 2'b01, M_PW = 2'b10, M_RSV = 2'b11} mode_e;

  localparam int ST = LAT - 2;
  localparam int CW = $clog2(LAT+1) + 1;
  localparam logic [2*W:0]   ONE_SH = {1'b1, {(2*W){1'b0}}};
  localparam logic [2*W-1:0] BM     = (2*W)'(ONE_SH / (2*W+1)'(Q));
  localparam logic [2*W-1:0] Q2     = (2*W)'(Q);
  localparam logic [W:0]     Q1     = (W+1)'(Q);

  // Barrett: quotient estimate never exceeds the true quotient and is short by at most 2
  function automatic logic [W-1:0] red(input logic [2*W-1:0] x);
    logic [2*W-1:0] qe;
    logic [2*W-1:0] r;
    qe = (2*W)'(({{(2*W){1'b0}}, x} * {{(2*W){1'b0}}, BM}) >> (2*W));
    r  = x - qe * Q2;
    if (r >= Q2) r = r - Q2;
    if (r >= Q2) r = r - Q2;
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] addq(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= Q1) s = s - Q1;
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] subq(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + Q1 - {1'b0, b};
    if (s >= Q1) s = s - Q1;
    return s[W-1:0];
  endfunction

  function automatic logic [2*W-1:0] mulw(input logic [W-1:0] a, input logic [W-1:0] b);
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  // {p1, p2}: p1 feeds a' (NTT/PW) or b' (INTT); p2 only used by pointwise
  function automatic logic [4*W-1:0] prods(input mode_e m, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] w);
    logic [2*W-1:0] p1;
    logic [2*W-1:0] p2;
    p1 = '0;
    p2 = '0;
    case (m)
      M_NTT:   p1 = mulw(w, b);
      M_INTT:  p1 = mulw(w, subq(a, b));
      M_PW: begin
        p1 = mulw(a, w);
        p2 = mulw(b, w);
      end
      default: ;
    endcase
    return {p1, p2};
  endfunction

  function automatic logic [2*W-1:0] fin(input mode_e m, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [2*W-1:0] p1,
                                         input logic [2*W-1:0] p2);
    logic [W-1:0] r1;
    r1 = red(p1);
    case (m)
      M_NTT:   return {addq(a, r1), subq(a, r1)};
      M_INTT:  return {addq(a, b), r1};
      M_PW:    return {r1, red(p2)};
      default: return {a, b};
    endcase
  endfunction

  logic [LAT-1:0]       vld;
  logic                 stall, advance, accept, hs;
  mode_e                m0;
  logic [LANES*W-1:0]   a0, b0, w0, ra, rb, rw, fa, fb;
  logic [2*LANES*W-1:0] p1n, p2n;
  mode_e                pm [1:ST];
  logic [LANES*W-1:0]   pa [1:ST];
  logic [LANES*W-1:0]   pb [1:ST];
  logic [2*LANES*W-1:0] p1 [1:ST];
  logic [2*LANES*W-1:0] p2 [1:ST];

  assign out_valid = vld[LAT-1];
  assign stall     = out_valid & ~out_ready;
  assign advance   = ~stall;
  assign in_ready  = advance;
  assign accept    = in_valid & in_ready;
  assign hs        = out_valid & out_ready;

  always_comb begin
    ra  = '0;
    rb  = '0;
    rw  = '0;
    p1n = '0;
    p2n = '0;
    fa  = '0;
    fb  = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      ra[l*W +: W] = red({{W{1'b0}}, a_in[l*W +: W]});
      rb[l*W +: W] = red({{W{1'b0}}, b_in[l*W +: W]});
      rw[l*W +: W] = red({{W{1'b0}}, omega_in[l*W +: W]});
      {p1n[l*2*W +: 2*W], p2n[l*2*W +: 2*W]} =
        prods(m0, a0[l*W +: W], b0[l*W +: W], w0[l*W +: W]);
      {fa[l*W +: W], fb[l*W +: W]} =
        fin(pm[ST], pa[ST][l*W +: W], pb[ST][l*W +: W],
            p1[ST][l*2*W +: 2*W], p2[ST][l*2*W +: 2*W]);
    end
  end

  // Datapath carries no reset: only the valid chain decides what reaches the output
  always_ff @(posedge clk) begin
    if (advance) begin
      m0    <= mode_e'(mode);
      a0    <= ra;
      b0    <= rb;
      w0    <= rw;
      pm[1] <= m0;
      pa[1] <= a0;
      pb[1] <= b0;
      p1[1] <= p1n;
      p2[1] <= p2n;
      for (int unsigned s = 2; s <= ST; s++) begin
        pm[s] <= pm[s-1];
        pa[s] <= pa[s-1];
        pb[s] <= pb[s-1];
        p1[s] <= p1[s-1];
        p2[s] <= p2[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld      <= '0;
      a_out    <= '0;
      b_out    <= '0;
      inflight <= '0;
      mode_err <= 1'b0;
    end else begin
      if (advance) begin
        vld   <= {vld[LAT-2:0], accept};
        a_out <= fa;
        b_out <= fb;
      end
      if (accept && !hs)      inflight <= inflight + CW'(1);
      else if (!accept && hs) inflight <= inflight - CW'(1);
      if (accept && mode == 2'b11) mode_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_butterfly_array.sv
// Scoreboard bench for butterfly_array: expected beats are queued on acceptance
// and compared, in order, whenever the DUT presents an output beat.
module tb_butterfly_array;
  localparam int LANES = 2;
  localparam int W     = 12;
  localparam int Q     = 3329;
  localparam int LAT   = 7;
  localparam int VW    = LANES * W;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [1:0]             mode;
  logic                   in_valid, in_ready, out_valid, out_ready, mode_err;
  logic [VW-1:0]          a_in, b_in, omega_in, a_out, b_out;
  logic [$clog2(LAT+1):0] inflight;

  butterfly_array #(.LANES(LANES), .W(W), .Q(Q), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .omega_in(omega_in), .out_valid(out_valid),
    .out_ready(out_ready), .a_out(a_out), .b_out(b_out), .inflight(inflight),
    .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] ea;
    logic [VW-1:0] eb;
    int            acc;
  } beat_t;

  beat_t sb[$];
  int    total = 0, bad = 0, cyc = 0, inf_m = 0, peak = 0, ndone = 0, nstall = 0;
  logic  err_m = 1'b0;
  bit    strict = 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic beat_t model(input logic [1:0] md, input logic [VW-1:0] a,
                                  input logic [VW-1:0] b, input logic [VW-1:0] w);
    beat_t  r;
    longint av, bv, wv, t, xa, xb;
    r.acc = 0;
    r.ea  = '0;
    r.eb  = '0;
    for (int l = 0; l < LANES; l++) begin
      av = longint'(a[l*W +: W]) % Q;
      bv = longint'(b[l*W +: W]) % Q;
      wv = longint'(w[l*W +: W]) % Q;
      case (md)
        2'b00: begin t = (wv * bv) % Q; xa = (av + t) % Q; xb = (av - t + Q) % Q; end
        2'b01: begin xa = (av + bv) % Q; xb = (wv * ((av - bv + Q) % Q)) % Q; end
        2'b10: begin xa = (av * wv) % Q; xb = (bv * wv) % Q; end
        default: begin xa = av; xb = bv; end
      endcase
      r.ea[l*W +: W] = W'(xa);
      r.eb[l*W +: W] = W'(xb);
    end
    return r;
  endfunction

  task automatic drive(input logic v, input logic [1:0] md, input logic [VW-1:0] a,
                       input logic [VW-1:0] b, input logic [VW-1:0] w, input logic ordy);
    in_valid  = v;
    mode      = md;
    a_in      = a;
    b_in      = b;
    omega_in  = w;
    out_ready = ordy;
  endtask

  // Called at posedge+1 with inputs driven; evaluates this cycle's handshakes
  task automatic tick(output bit acc);
    beat_t e;
    bit    ohs;
    #1;
    chk("inflight", inflight, inf_m);
    chk("mode_err", mode_err, err_m);
    if (int'(inflight) > peak) peak = int'(inflight);
    if (out_valid && !out_ready) begin
      nstall++;
      chk("stall_rdy", in_ready, 0);
    end
    acc = in_valid && in_ready;
    ohs = out_valid && out_ready;
    if (out_valid) begin
      if (sb.size() == 0) chk("stale_out", out_valid, 0);
      else begin
        chk("a_out", a_out, sb[0].ea);
        chk("b_out", b_out, sb[0].eb);
        for (int l = 0; l < LANES; l++) begin
          chk("a_ltq", a_out[l*W +: W] < Q, 1);
          chk("b_ltq", b_out[l*W +: W] < Q, 1);
        end
        if (ohs) begin
          if (strict) chk("latency", cyc - sb[0].acc, LAT);
          else        chk("lat_min", (cyc - sb[0].acc) >= LAT, 1);
          void'(sb.pop_front());
          ndone++;
        end
      end
    end
    if (acc) begin
      e     = model(mode, a_in, b_in, omega_in);
      e.acc = cyc;
      sb.push_back(e);
      if (mode == 2'b11) err_m = 1'b1;
    end
    inf_m = inf_m + int'(acc) - int'(ohs);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [1:0] md, input logic [VW-1:0] a, input logic [VW-1:0] b,
                      input logic [VW-1:0] w);
    bit acc;
    drive(1'b1, md, a, b, w, 1'b1);
    tick(acc);
    chk("accept", acc, 1);
  endtask

  task automatic drain(input int max);
    bit acc;
    int n;
    n = 0;
    drive(1'b0, 2'b00, '0, '0, '0, 1'b1);
    while (sb.size() > 0 && n < max) begin
      tick(acc);
      n++;
    end
    chk("drain", sb.size(), 0);
    tick(acc);
    chk("inf_zero", inflight, 0);
  endtask

  logic [VW-1:0] ta[10], tb_[10], tw[10];
  logic [1:0]    tm[10];

  initial begin
    bit acc;
    int sent, k;

    reset = 1'b0;
    drive(1'b0, 2'b00, '0, '0, '0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ovalid", out_valid, 0);
    chk("rst_a", a_out, 0);
    chk("rst_b", b_out, 0);
    chk("rst_inf", inflight, 0);
    chk("rst_err", mode_err, 0);
    chk("rst_irdy", in_ready, 1);
    reset = 1'b1;

    // Directed vectors: lane1 in the upper W bits
    send(2'b00, {12'd3328, 12'd100}, {12'd1, 12'd200}, {12'd17, 12'd17});
    drain(20);
    send(2'b01, {12'd171, 12'd171}, {12'd29, 12'd29}, {12'd17, 12'd17});
    send(2'b00, {12'd4095, 12'd4095}, {12'd4095, 12'd4095}, {12'd17, 12'd17});
    send(2'b10, {12'd1000, 12'd1000}, {12'd500, 12'd500}, {12'd196, 12'd196});
    send(2'b11, {12'd3500, 12'd3500}, {12'd5, 12'd5}, {12'd9, 12'd9});
    drain(20);
    chk("err_sticky", mode_err, 1);

    // Back-to-back stream with a 4-cycle output stall
    strict = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tm[i]  = 2'($urandom_range(0, 3));
      ta[i]  = VW'($urandom);
      tb_[i] = VW'($urandom);
      tw[i]  = VW'($urandom);
    end
    peak   = 0;
    nstall = 0;
    ndone  = 0;
    sent   = 0;
    k      = 0;
    while ((sent < 10 || sb.size() > 0) && k < 40) begin
      if (sent < 10) drive(1'b1, tm[sent], ta[sent], tb_[sent], tw[sent], !(k >= 9 && k <= 12));
      else           drive(1'b0, 2'b00, '0, '0, '0, !(k >= 9 && k <= 12));
      tick(acc);
      if (acc) sent++;
      k++;
    end
    chk("stall_sent", sent, 10);
    chk("stall_done", ndone, 10);
    chk("stall_cycles", nstall, 4);
    chk("inf_peak", peak, LAT);
    drain(20);

    // Reset with four beats in flight
    strict = 1'b1;
    for (int i = 0; i < 4; i++) send(2'b10, VW'($urandom), VW'($urandom), VW'($urandom));
    chk("inf_pre_rst", inflight, 4);
    drive(1'b0, 2'b00, '0, '0, '0, 1'b1);
    reset = 1'b0;
    #1;
    chk("arst_ovalid", out_valid, 0);
    chk("arst_inf", inflight, 0);
    chk("arst_err", mode_err, 0);
    sb.delete();
    inf_m = 0;
    err_m = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 12; i++) tick(acc);

    // Random regression with random backpressure
    strict = 1'b0;
    sent   = 0;
    k      = 0;
    while (sent < 10000 && k < 40000) begin
      drive($urandom_range(0, 9) < 8, 2'($urandom_range(0, 3)), VW'($urandom),
            VW'($urandom), VW'($urandom), $urandom_range(0, 9) < 7);
      tick(acc);
      if (acc) sent++;
      k++;
    end
    chk("rand_sent", sent, 10000);
    drain(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
